preg_alloc_ctrl: RTL and testbench

Physical-register allocation controller sitting between the dual-issue rename stage, the commit stage and the physical-register free list. Grants up to two destination physical registers per cycle to an in-order rename bundle, buffers up to two released physical registers per cycle from commit in a small queue, and drains them into the free list. A flush state machine blocks renaming until all pending releases are returned. Keeps a mirror count of free registers.

---
 rtl/preg_alloc_ctrl.sv | 138 +++++++++++++
 tb/tb_preg_alloc_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_alloc_ctrl.sv
// Physical-register allocation controller: grants rename destination tags from the
// free list, queues commit releases and drains them back, with a flush drain FSM.
module preg_alloc_ctrl #(
    parameter int DATA_WIDTH  = 7,
    parameter int RAM_DEPTH   = 128,
    parameter int L_REGISTERS = 32,
    parameter int RQ_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              ren_valid,
    input  logic [1:0]              ren_need_dst,
    output logic                    ren_ready,
    output logic [1:0]              ren_out_valid,
    output logic [2*DATA_WIDTH-1:0] ren_preg,
    input  logic                    fl_valid_1,
    input  logic                    fl_valid_2,
    input  logic [DATA_WIDTH-1:0]   fl_pop_data_1,
    input  logic [DATA_WIDTH-1:0]   fl_pop_data_2,
    output logic                    fl_pop_1,
    output logic                    fl_pop_2,
    output logic                    fl_push,
    output logic                    fl_push_2,
    output logic [DATA_WIDTH-1:0]   fl_push_data,
    output logic [DATA_WIDTH-1:0]   fl_push_data_2,
    input  logic                    fl_ready,
    input  logic [1:0]              rel_valid,
    input  logic [2*DATA_WIDTH-1:0] rel_preg,
    output logic                    rel_ready,
    input  logic                    flush,
    output logic                    flush_done,
    output logic [7:0]              free_cnt
);
    localparam int PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]              r_state;
    logic [DATA_WIDTH-1:0]   r_rq [RQ_DEPTH];
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic [7:0]              r_free_cnt;
    logic [1:0]              r_out_valid;
    logic [2*DATA_WIDTH-1:0] r_preg;
    logic                    r_flush_done;

    logic [1:0]    w_need;
    logic [1:0]    w_grant;
    logic          w_n_zero;
    logic          w_n_one;
    logic          w_n_two;
    logic          w_accept;
    logic [1:0]    w_pop_cnt;
    logic [1:0]    w_push_cnt;
    logic [1:0]    w_enq_cnt;
    logic          w_enq_0;
    logic          w_enq_1;
    logic          w_push_1;
    logic          w_push_2;
    logic [PW-1:0] w_rptr_p1;
    logic [PW-1:0] w_wptr_slot1;
    logic [8:0]    w_free_ext;
    logic          w_drain_exit;

    assign w_need   = ren_valid & ren_need_dst;
    assign w_n_zero = (w_need == 2'b00);
    assign w_n_one  = ^w_need;
    assign w_n_two  = &w_need;
    assign w_accept = (r_state == ST_RUN) & ~flush &
                      (w_n_zero | (w_n_one & fl_valid_1) | (w_n_two & fl_valid_2));
    assign w_grant  = w_accept ? w_need : 2'b00;

    assign ren_ready = w_accept;
    assign fl_pop_1  = w_accept & (|ren_valid) & ~w_n_zero;
    assign fl_pop_2  = w_accept & (|ren_valid) & w_n_two;
    assign w_pop_cnt = {1'b0, fl_pop_1} + {1'b0, fl_pop_2};

    // Drain uses only registered occupancy and the mirrored count, never rel_valid
    assign w_free_ext = {1'b0, r_free_cnt};
    assign w_push_1   = fl_ready & (r_count != '0) & ((w_free_ext + 9'd1) <= 9'(RAM_DEPTH));
    assign w_push_2   = fl_ready & (r_count >= CW'(2)) & ((w_free_ext + 9'd2) <= 9'(RAM_DEPTH));
    assign w_push_cnt = {1'b0, w_push_1} + {1'b0, w_push_2};
    assign w_rptr_p1  = r_rptr + PW'(1);

    assign fl_push        = w_push_1;
    assign fl_push_2      = w_push_2;
    assign fl_push_data   = r_rq[r_rptr];
    assign fl_push_data_2 = r_rq[w_rptr_p1];

    assign rel_ready    = (r_count <= CW'(RQ_DEPTH - 2));
    assign w_enq_0      = rel_ready & rel_valid[0];
    assign w_enq_1      = rel_ready & rel_valid[1];
    assign w_enq_cnt    = {1'b0, w_enq_0} + {1'b0, w_enq_1};
    assign w_wptr_slot1 = w_enq_0 ? (r_wptr + PW'(1)) : r_wptr;

    assign w_drain_exit = (r_state == ST_DRAIN) & (r_count == '0) & (rel_valid == 2'b00);

    assign ren_out_valid = r_out_valid;
    assign ren_preg      = r_preg;
    assign flush_done    = r_flush_done;
    assign free_cnt      = r_free_cnt;

    // Queue storage needs no reset; pointers and count define what is live
    always_ff @(posedge clk) begin
        if (w_enq_0) r_rq[r_wptr] <= rel_preg[DATA_WIDTH-1:0];
        if (w_enq_1) r_rq[w_wptr_slot1] <= rel_preg[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_free_cnt   <= 8'(RAM_DEPTH - L_REGISTERS);
            r_out_valid  <= 2'b00;
            r_preg       <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_wptr       <= r_wptr + PW'(w_enq_cnt);
            r_rptr       <= r_rptr + PW'(w_push_cnt);
            r_count      <= r_count + CW'(w_enq_cnt) - CW'(w_push_cnt);
            r_free_cnt   <= r_free_cnt + 8'(w_push_cnt) - 8'(w_pop_cnt);
            r_out_valid  <= w_grant;
            r_preg[DATA_WIDTH-1:0] <= w_grant[0] ? fl_pop_data_1 : '0;
            r_preg[2*DATA_WIDTH-1:DATA_WIDTH] <=
                w_grant[1] ? (w_grant[0] ? fl_pop_data_2 : fl_pop_data_1) : '0;
            r_flush_done <= w_drain_exit;
            case (r_state)
                ST_RUN:  if (flush) r_state <= ST_DRAIN;
                default: if (w_drain_exit) r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Self-checking bench for preg_alloc_ctrl: table vectors, directed corner sequences
// and a randomized run, all checked against a queue-based reference model.
module tb_preg_alloc_ctrl;
    localparam int DW    = 7;
    localparam int RQD   = 4;
    localparam int DEPTH = 128;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     renValid, renNeedDst, renOutValid, relValid;
    logic           renReady, flValid1, flValid2, flPop1, flPop2, flPush, flPush2;
    logic [2*DW-1:0] renPreg, relPreg;
    logic [DW-1:0]  flData1, flData2, flPushData, flPushData2;
    logic           flReady, relReady, flush, flushDone;
    logic [7:0]     freeCnt;

    preg_alloc_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .L_REGISTERS(32), .RQ_DEPTH(RQD)) dut (
        .clk(clk), .rst(rst),
        .ren_valid(renValid), .ren_need_dst(renNeedDst), .ren_ready(renReady),
        .ren_out_valid(renOutValid), .ren_preg(renPreg),
        .fl_valid_1(flValid1), .fl_valid_2(flValid2),
        .fl_pop_data_1(flData1), .fl_pop_data_2(flData2),
        .fl_pop_1(flPop1), .fl_pop_2(flPop2),
        .fl_push(flPush), .fl_push_2(flPush2),
        .fl_push_data(flPushData), .fl_push_data_2(flPushData2),
        .fl_ready(flReady), .rel_valid(relValid), .rel_preg(relPreg), .rel_ready(relReady),
        .flush(flush), .flush_done(flushDone), .free_cnt(freeCnt)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    int          mFree;
    logic [DW-1:0] mRq[$];
    bit          mDrain;
    logic [1:0]  mOutValid;
    logic [2*DW-1:0] mPreg;
    bit          mFlushDone;

    // DUT values captured mid-cycle, used by sequences and the free-list environment
    logic sReady, sPop1, sPop2, sPush, sPush2, sRelReady, sFlushDone;
    logic [DW-1:0] sPushD1, sPushD2;

    typedef struct packed {
        logic [1:0] valid;
        logic [1:0] need;
        logic       fl1;
        logic       fl2;
        logic       expReady;
        logic       expPop1;
        logic       expPop2;
        logic [1:0] expOutValid;
    } vec_t;
    vec_t vecs[8];

    logic [DW-1:0] flq[$];
    logic [DW-1:0] alloc[$];
    int idx, pulses, guard, freeBefore;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mFree = 96;
        mRq.delete();
        mDrain = 0;
        mOutValid = 2'b00;
        mPreg = '0;
        mFlushDone = 0;
    endtask

    task automatic setIdle();
        renValid = 2'b00; renNeedDst = 2'b00;
        relValid = 2'b00; relPreg = '0;
        flush = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        setIdle();
        flValid1 = 1'b0; flValid2 = 1'b0; flData1 = '0; flData2 = '0; flReady = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_free_cnt", freeCnt, 96);
        checkOutput("reset_rel_ready", relReady, 1);
        checkOutput("reset_ren_out_valid", renOutValid, 0);
        checkOutput("reset_ren_preg", renPreg, 0);
        checkOutput("reset_flush_done", flushDone, 0);
        checkOutput("reset_fl_pop_1", flPop1, 0);
        checkOutput("reset_fl_push", flPush, 0);
    endtask

    // One clock cycle: inputs already driven; check combinational outputs, then registered ones
    task automatic applyStimulus();
        int n, pops, pushes;
        bit acc, relRdy, exitDrain;
        logic [1:0] grant;
        logic [2*DW-1:0] nPreg;
        logic [DW-1:0] tmp;
        #2;
        n = $countones(renValid & renNeedDst);
        acc = !mDrain && !flush && (n == 0 || (n == 1 && flValid1) || (n == 2 && flValid2));
        pops = acc ? n : 0;
        relRdy = (RQD - mRq.size()) >= 2;
        pushes = 0;
        if (flReady) begin
            if (mRq.size() >= 2 && mFree + 2 <= DEPTH) pushes = 2;
            else if (mRq.size() >= 1 && mFree + 1 <= DEPTH) pushes = 1;
        end
        sReady = renReady; sPop1 = flPop1; sPop2 = flPop2; sPush = flPush; sPush2 = flPush2;
        sPushD1 = flPushData; sPushD2 = flPushData2; sRelReady = relReady;
        checkOutput("ren_ready", sReady, acc);
        checkOutput("fl_pop_1", sPop1, pops >= 1);
        checkOutput("fl_pop_2", sPop2, pops == 2);
        checkOutput("rel_ready", sRelReady, relRdy);
        checkOutput("fl_push", sPush, pushes >= 1);
        checkOutput("fl_push_2", sPush2, pushes == 2);
        if (pushes >= 1) checkOutput("fl_push_data", sPushD1, mRq[0]);
        if (pushes == 2) checkOutput("fl_push_data_2", sPushD2, mRq[1]);

        grant = acc ? (renValid & renNeedDst) : 2'b00;
        nPreg = '0;
        if (grant == 2'b11)      nPreg = {flData2, flData1};
        else if (grant == 2'b01) nPreg[DW-1:0] = flData1;
        else if (grant == 2'b10) nPreg[2*DW-1:DW] = flData1;
        exitDrain = mDrain && mRq.size() == 0 && relValid == 2'b00;
        for (int p = 0; p < pushes; p++) tmp = mRq.pop_front();
        if (relRdy) begin
            if (relValid[0]) mRq.push_back(relPreg[DW-1:0]);
            if (relValid[1]) mRq.push_back(relPreg[2*DW-1:DW]);
        end
        mFree = mFree + pushes - pops;
        mDrain = mDrain ? !exitDrain : flush;
        mFlushDone = exitDrain;
        mOutValid = grant;
        mPreg = nPreg;

        @(posedge clk); #1;
        sFlushDone = flushDone;
        checkOutput("ren_out_valid", renOutValid, mOutValid);
        checkOutput("ren_preg", renPreg, mPreg);
        checkOutput("free_cnt", freeCnt, mFree);
        checkOutput("flush_done", flushDone, mFlushDone);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //            valid  need  fl1 fl2 rdy pop1 pop2 outValid
        vecs[0] = '{2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10};
        vecs[1] = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[2] = '{2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01};
        vecs[3] = '{2'b00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[4] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[5] = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[6] = '{2'b10, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10};
        vecs[7] = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11};

        resetDut();

        // First double grant after reset
        flValid1 = 1'b1; flValid2 = 1'b1; flData1 = 7'd32; flData2 = 7'd33; flReady = 1'b1;
        renValid = 2'b11; renNeedDst = 2'b11;
        applyStimulus();
        checkOutput("first_pop_1", sPop1, 1);
        checkOutput("first_pop_2", sPop2, 1);
        checkOutput("first_preg", renPreg, {7'd33, 7'd32});
        checkOutput("first_free_cnt", freeCnt, 94);

        flData1 = 7'd50; flData2 = 7'd51;
        for (int i = 0; i < 8; i++) begin
            setIdle();
            renValid = vecs[i].valid; renNeedDst = vecs[i].need;
            flValid1 = vecs[i].fl1; flValid2 = vecs[i].fl2;
            applyStimulus();
            checkOutput($sformatf("vec%0d_ready", i), sReady, vecs[i].expReady);
            checkOutput($sformatf("vec%0d_pop1", i), sPop1, vecs[i].expPop1);
            checkOutput($sformatf("vec%0d_pop2", i), sPop2, vecs[i].expPop2);
            checkOutput($sformatf("vec%0d_out_valid", i), renOutValid, vecs[i].expOutValid);
        end
        checkOutput("vec_slot1_gets_head", 32'(vecs[0].expOutValid), 32'd2);

        // Release 40,41 reaches the free list one cycle later
        setIdle(); flReady = 1'b1;
        relValid = 2'b11; relPreg = {7'd41, 7'd40};
        applyStimulus();
        checkOutput("rel_same_cycle_push", sPush, 0);
        setIdle();
        applyStimulus();
        checkOutput("rel_push", sPush, 1);
        checkOutput("rel_push_2", sPush2, 1);
        checkOutput("rel_push_data", sPushD1, 40);
        checkOutput("rel_push_data_2", sPushD2, 41);
        checkOutput("rel_free_cnt", freeCnt, 91);

        // Fill the queue with the free list stalled, then drain across the wrap
        flReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            setIdle(); relValid = 2'b11;
            relPreg = {7'(61 + 2 * i), 7'(60 + 2 * i)};
            applyStimulus();
        end
        setIdle();
        applyStimulus();
        checkOutput("rq_full_rel_ready", sRelReady, 0);
        flReady = 1'b1;
        applyStimulus();
        checkOutput("wrap_push_a", sPushD1, 60);
        relValid = 2'b11; relPreg = {7'd65, 7'd64};
        applyStimulus();
        checkOutput("wrap_push_b", sPushD2, 63);
        setIdle();
        applyStimulus();
        checkOutput("wrap_push_c", sPushD1, 64);
        checkOutput("wrap_push_c2", sPushD2, 65);

        // Double pop, double push and double enqueue in one cycle
        flReady = 1'b0; setIdle();
        relValid = 2'b11; relPreg = {7'd71, 7'd70};
        applyStimulus();
        flReady = 1'b1; flValid1 = 1'b1; flValid2 = 1'b1; flData1 = 7'd52; flData2 = 7'd53;
        renValid = 2'b11; renNeedDst = 2'b11;
        relValid = 2'b11; relPreg = {7'd73, 7'd72};
        freeBefore = mFree;
        applyStimulus();
        checkOutput("simul_free_cnt", freeCnt, freeBefore);
        checkOutput("simul_push_2", sPush2, 1);
        setIdle();
        applyStimulus();
        checkOutput("simul_count_kept", sPushD1, 72);

        // Flush with three queued releases
        flReady = 1'b0; setIdle();
        relValid = 2'b11; relPreg = {7'd81, 7'd80};
        applyStimulus();
        setIdle(); relValid = 2'b01; relPreg = {7'd0, 7'd82};
        applyStimulus();
        setIdle(); flush = 1'b1; renValid = 2'b11; renNeedDst = 2'b11;
        applyStimulus();
        checkOutput("flush_ren_ready", sReady, 0);
        flush = 1'b0;
        applyStimulus();
        checkOutput("drain_ren_ready", sReady, 0);
        flReady = 1'b1; setIdle();
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            if (sFlushDone === 1'b1) pulses++;
        end
        checkOutput("flush_done_pulses", pulses, 1);
        renValid = 2'b11; renNeedDst = 2'b11;
        applyStimulus();
        checkOutput("resume_ren_ready", sReady, 1);

        // Bring the mirror to 127, then check the free list never overflows
        setIdle(); guard = 0;
        while (mFree + mRq.size() + 2 <= 127 && guard < 200) begin
            relValid = 2'b11; relPreg = {7'(guard), 7'(guard + 1)};
            applyStimulus(); guard++;
        end
        while (mFree + mRq.size() < 127 && guard < 200) begin
            relValid = 2'b01; relPreg = {7'd0, 7'(guard)};
            applyStimulus(); guard++;
        end
        setIdle();
        repeat (3) applyStimulus();
        checkOutput("free_cnt_127", freeCnt, 127);
        flReady = 1'b0; relValid = 2'b11; relPreg = {7'd101, 7'd100};
        applyStimulus();
        flReady = 1'b1; setIdle();
        applyStimulus();
        checkOutput("cap_single_push", sPush, 1);
        checkOutput("cap_no_push_2", sPush2, 0);
        applyStimulus();
        checkOutput("cap_full_no_push", sPush, 0);
        checkOutput("cap_free_cnt_128", freeCnt, 128);
        renValid = 2'b11; renNeedDst = 2'b11;
        applyStimulus();
        setIdle();
        applyStimulus();

        // Reset in the middle of a drain
        flReady = 1'b0; setIdle();
        relValid = 2'b11; relPreg = {7'd91, 7'd90};
        applyStimulus();
        setIdle(); flush = 1'b1;
        applyStimulus();
        setIdle();
        applyStimulus();
        resetDut();
        renValid = 2'b01; renNeedDst = 2'b00;
        applyStimulus();
        checkOutput("post_reset_ready", sReady, 1);
        checkOutput("post_reset_rel_ready", sRelReady, 1);

        // Randomized run with a consistent free-list environment
        flq.delete(); alloc.delete();
        for (int t = 32; t < 128; t++) flq.push_back(7'(t));
        for (int t = 0; t < 32; t++) alloc.push_back(7'(t));
        for (int cyc = 0; cyc < 400; cyc++) begin
            flValid1 = flq.size() >= 1;
            flValid2 = flq.size() >= 2;
            flData1 = (flq.size() >= 1) ? flq[0] : '0;
            flData2 = (flq.size() >= 2) ? flq[1] : '0;
            flReady = ($urandom_range(0, 4) != 0);
            renValid = 2'($urandom_range(0, 3));
            renNeedDst = 2'($urandom_range(0, 3));
            flush = ($urandom_range(0, 29) == 0);
            relValid = 2'b00; relPreg = '0;
            if ((RQD - mRq.size()) >= 2 && $urandom_range(0, 2) != 0) begin
                for (int s = 0; s < 2; s++) begin
                    if (alloc.size() > 0 && $urandom_range(0, 1) == 1) begin
                        idx = int'($urandom_range(0, alloc.size() - 1));
                        relPreg[s*DW +: DW] = alloc[idx];
                        alloc.delete(idx);
                        relValid[s] = 1'b1;
                    end
                end
            end
            applyStimulus();
            if (sPop1 === 1'b1 && flq.size() > 0) alloc.push_back(flq.pop_front());
            if (sPop2 === 1'b1 && flq.size() > 0) alloc.push_back(flq.pop_front());
            if (sPush === 1'b1) flq.push_back(sPushD1);
            if (sPush2 === 1'b1) flq.push_back(sPushD2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
